// File: rtl/conv_sample_seq.sv
// conv_sample_seq: per-sample conv sequencer (init/exec/drain/fin/out) plus weight/bias load addressing
module conv_sample_seq #(
  parameter int CORE_LAT = 2,
  parameter int F_NUM    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        wwrite,
  input  logic        bwrite,
  input  logic        src_valid,
  input  logic        src_ready,
  input  logic        s_init,
  output logic        s_fin,
  output logic        k_init,
  output logic        exec,
  output logic [11:0] ia,
  output logic        k_fin,
  output logic [3:0]  ra,
  output logic        outr,
  output logic [11:0] oa,
  output logic [3:0]  kn,
  output logic [9:0]  prm_a,
  output logic [9:0]  wa,
  output logic        busy,
  input  logic [3:0]  id,
  input  logic [9:0]  is,
  input  logic [4:0]  ih,
  input  logic [4:0]  iw,
  input  logic [3:0]  od,
  input  logic [9:0]  os,
  input  logic [4:0]  oh,
  input  logic [4:0]  ow,
  input  logic [9:0]  fs,
  input  logic [9:0]  ks,
  input  logic [4:0]  kh,
  input  logic [4:0]  kw
);
  typedef enum logic [2:0] {IDLE, INIT, EXEC, DRAIN, FIN, OUT, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0]  c_q, c_d;
  logic [4:0]  ky_q, ky_d, kx_q, kx_d, oy_q, oy_d, ox_q, ox_d, j_q, j_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic [11:0] irow_q, irow_d, ipix_q, ipix_d, ich_q, ich_d, ikrow_q, ikrow_d;
  logic [11:0] opix_q, opix_d, oacc_q, oacc_d;
  logic [9:0]  wch_q, wch_d;
  logic        k_init_q, k_init_d, exec_q, exec_d, k_fin_q, k_fin_d, outr_q, outr_d;
  logic        s_fin_q, s_fin_d, busy_q, busy_d;
  logic [11:0] ia_q, ia_d, oa_q, oa_d;
  logic [9:0]  wa_q, wa_d, prm_a_q, prm_a_d;
  logic [3:0]  ra_q, ra_d, kn_q, kn_d;
  logic        cfg_ok, load, beat, wrap;
  assign cfg_ok = (od != 4'd0) && (5'(od) <= 5'(F_NUM)) && (ih >= kh);
  assign load   = (state_q == IDLE) && !run && (wwrite || bwrite);
  assign beat   = load && src_valid && src_ready;
  assign wrap   = bwrite || (prm_a_q == fs - 10'd1);
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    j_d     = j_q;
    dcnt_d  = dcnt_q;
    irow_d  = irow_q;
    ipix_d  = ipix_q;
    ich_d   = ich_q;
    ikrow_d = ikrow_q;
    opix_d  = opix_q;
    oacc_d  = oacc_q;
    wch_d   = wch_q;
    ia_d    = 12'd0;
    wa_d    = 10'd0;
    ra_d    = 4'd0;
    outr_d  = 1'b0;
    oa_d    = 12'd0;
    unique case (state_q)
      IDLE: if (s_init && run && cfg_ok) begin
        state_d = INIT;
        oy_d    = 5'd0;
        ox_d    = 5'd0;
        irow_d  = 12'd0;
        ipix_d  = 12'd0;
        opix_d  = 12'd0;
      end
      INIT: begin
        state_d = EXEC;
        c_d     = 4'd0;
        ky_d    = 5'd0;
        kx_d    = 5'd0;
        ich_d   = ipix_q;
        ikrow_d = ipix_q;
        wch_d   = 10'd0;
        ia_d    = ipix_q;
      end
      EXEC: if (kx_q != kw - 5'd1) begin
        kx_d = kx_q + 5'd1;
        ia_d = ia_q + 12'd1;
        wa_d = wa_q + 10'd1;
      end else if (ky_q != kh - 5'd1) begin
        kx_d    = 5'd0;
        ky_d    = ky_q + 5'd1;
        ikrow_d = ikrow_q + 12'(iw);
        ia_d    = ikrow_d;
        wa_d    = wa_q + 10'd1;
      end else if (c_q != id - 4'd1) begin
        kx_d    = 5'd0;
        ky_d    = 5'd0;
        c_d     = c_q + 4'd1;
        ich_d   = ich_q + 12'(is);
        ikrow_d = ich_d;
        ia_d    = ich_d;
        wch_d   = wch_q + ks;
        wa_d    = wch_d;
      end else begin
        state_d = (CORE_LAT == 0) ? FIN : DRAIN;
        dcnt_d  = 8'd0;
      end
      DRAIN: begin
        dcnt_d  = dcnt_q + 8'd1;
        state_d = (dcnt_q == 8'(CORE_LAT - 1)) ? FIN : DRAIN;
      end
      FIN: begin
        state_d = OUT;
        j_d     = 5'd0;
        oacc_d  = opix_q;
      end
      OUT: if (j_q == {1'b0, od}) begin
        opix_d = opix_q + 12'd1;
        if (ox_q == ow - 5'd1) begin
          ox_d   = 5'd0;
          oy_d   = oy_q + 5'd1;
          irow_d = irow_q + 12'(iw);
          ipix_d = irow_d;
        end else begin
          ox_d   = ox_q + 5'd1;
          ipix_d = ipix_q + 12'd1;
        end
        state_d = (oy_d == oh) ? DONE : INIT;
      end else begin
        // result write trails the ra select by one cycle to match the registered sum[ra]
        j_d    = j_q + 5'd1;
        ra_d   = (j_d < {1'b0, od}) ? j_d[3:0] : 4'd0;
        outr_d = 1'b1;
        oa_d   = oacc_q;
        oacc_d = oacc_q + 12'(os);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    k_init_d = state_d == INIT;
    exec_d   = state_d == EXEC;
    k_fin_d  = state_d == FIN;
    s_fin_d  = state_d == DONE;
    busy_d   = (state_d != IDLE) && (state_d != DONE);
    kn_d     = !(wwrite || bwrite) ? 4'd0 : (beat && wrap) ? kn_q + 4'd1 : kn_q;
    prm_a_d  = !(wwrite || bwrite) ? 10'd0 : !beat ? prm_a_q : wrap ? 10'd0 : prm_a_q + 10'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      c_q      <= '0;
      ky_q     <= '0;
      kx_q     <= '0;
      oy_q     <= '0;
      ox_q     <= '0;
      j_q      <= '0;
      dcnt_q   <= '0;
      irow_q   <= '0;
      ipix_q   <= '0;
      ich_q    <= '0;
      ikrow_q  <= '0;
      opix_q   <= '0;
      oacc_q   <= '0;
      wch_q    <= '0;
      k_init_q <= 1'b0;
      exec_q   <= 1'b0;
      k_fin_q  <= 1'b0;
      outr_q   <= 1'b0;
      s_fin_q  <= 1'b0;
      busy_q   <= 1'b0;
      ia_q     <= '0;
      oa_q     <= '0;
      wa_q     <= '0;
      ra_q     <= '0;
      kn_q     <= '0;
      prm_a_q  <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      ky_q     <= ky_d;
      kx_q     <= kx_d;
      oy_q     <= oy_d;
      ox_q     <= ox_d;
      j_q      <= j_d;
      dcnt_q   <= dcnt_d;
      irow_q   <= irow_d;
      ipix_q   <= ipix_d;
      ich_q    <= ich_d;
      ikrow_q  <= ikrow_d;
      opix_q   <= opix_d;
      oacc_q   <= oacc_d;
      wch_q    <= wch_d;
      k_init_q <= k_init_d;
      exec_q   <= exec_d;
      k_fin_q  <= k_fin_d;
      outr_q   <= outr_d;
      s_fin_q  <= s_fin_d;
      busy_q   <= busy_d;
      ia_q     <= ia_d;
      oa_q     <= oa_d;
      wa_q     <= wa_d;
      ra_q     <= ra_d;
      kn_q     <= kn_d;
      prm_a_q  <= prm_a_d;
    end
  end
  assign s_fin  = s_fin_q;
  assign k_init = k_init_q;
  assign exec   = exec_q;
  assign ia     = ia_q;
  assign k_fin  = k_fin_q;
  assign ra     = ra_q;
  assign outr   = outr_q;
  assign oa     = oa_q;
  assign kn     = kn_q;
  assign prm_a  = prm_a_q;
  assign wa     = wa_q;
  assign busy   = busy_q;
endmodule

// File: doc/conv_sample_seq.md
Name: conv_sample_seq

Overview:
Sample-level sequencer for the tiny_dnn convolution engine. It responds to the batch controller's s_init request and returns s_fin. In between, it drives the 16 parallel cores and the src/dst buffers with k_init, exec, k_fin, outr and the ia/wa/ra/oa addresses for one forward-pass sample. Outside a run, it generates the kn/prm_a addressing for weight and bias loading from the source stream.

Parameters:
CORE_LAT, 2, idle cycles between the last exec and k_fin, covering core MAC pipeline drain.
F_NUM, 16, number of parallel cores; also the upper bound of od.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  forward-pass mode enable
wwrite  in  1  weight-load mode
bwrite  in  1  bias-load mode
src_valid  in  1  source stream valid
src_ready  in  1  source stream ready, driven by the batch controller
s_init  in  1  one-cycle sample start from the batch controller
s_fin  out  1  one-cycle sample done pulse
k_init  out  1  clear core accumulators
exec  out  1  core MAC enable; src buffer read enable
ia  out  12  src buffer read address
k_fin  out  1  end of accumulation (bias add)
ra  out  4  core result select
outr  out  1  dst buffer write enable
oa  out  12  dst buffer write address
kn  out  4  core select during weight/bias load
prm_a  out  10  parameter write address during load
wa  out  10  weight read address during exec
busy  out  1  sample in progress
id/is/ih/iw  in  4/10/5/5  input depth, plane size, height, width
od/os/oh/ow  in  4/10/5/5  output depth, plane size, height, width
fs/ks/kh/kw  in  10/10/5/5  filter size, kernel plane size, kernel height, kernel width

Behaviour:
- All outputs are registered. Reset value of every output is 0. The FSM resets to IDLE.
- Reset is asynchronous and may occur in any state. It returns the FSM to IDLE immediately, with all pulses low and all counters 0.
- States: IDLE, INIT, EXEC, DRAIN, FIN, OUT, DONE.
- IDLE:
  - s_init is accepted only when run=1 and the FSM is in IDLE. Otherwise s_init is ignored.
  - On accepting s_init, set oy=ox=0 and go to INIT. busy goes high the next cycle.
- INIT: k_init=1 for 1 cycle, then EXEC.
- EXEC:
  - Runs id*kh*kw cycles with exec=1.
  - Loop nest is c (outer), ky, kx (inner).
  - ia = c*is + (oy+ky)*iw + (ox+kx).
  - wa = c*ks + ky*kw + kx.
  - Addresses are computed by incremental adders; no multipliers are used.
- DRAIN: CORE_LAT cycles with all strobes low.
- FIN: k_fin=1 for 1 cycle.
- OUT:
  - Runs od+1 cycles.
  - In cycle j (j<od), ra=j.
  - In cycle j+1, outr=1 and oa = j*os + oy*ow + ox. This one-cycle skew matches the registered sum[ra] path.
- After OUT, advance ox; wrap ox at ow to 0 and increment oy.
  - If oy reaches oh, go to DONE.
  - Otherwise go to INIT.
- DONE: s_fin=1 for 1 cycle, busy=0, then IDLE.
- Per-pixel cycle count: 3 + id*kh*kw + CORE_LAT + od.
- Load mode (wwrite|bwrite, FSM in IDLE, run=0):
  - Each accepted beat (src_valid&src_ready) advances prm_a.
  - On the beat that leaves prm_a == fs-1 (bias: prm_a == 0, i.e. one value per core), prm_a wraps to 0 and kn increments.
  - kn wraps 15 -> 0.
  - With no beat, kn and prm_a hold.
  - Deasserting both wwrite and bwrite clears kn and prm_a.
- Address widths: ia and oa truncate to 12 bits; wa truncates to 10 bits. Configurations must fit in these widths; out-of-range configurations are undefined.
- od=0 is illegal; od > F_NUM is illegal.

Test Plan:
1. id=1, ih=iw=3, kh=kw=2, oh=ow=2, od=2, is=9, ks=4, os=4, CORE_LAT=2, s_init sampled at edge 0:
   - k_init high in cycle 1.
   - Pixel 0: ia 0,1,3,4 and wa 0,1,2,3 in cycles 2-5; k_fin in cycle 8; ra 0,1 in cycles 9-10; outr with oa 0,4 in cycles 10-11.
   - Pixel 1: ia 1,2,4,5.
   - s_fin in cycle 45.
2. id=2, same shape otherwise: pixel 0 ia 0,1,3,4,9,10,12,13 with wa 0..7. Per-pixel length is 15 cycles; s_fin in cycle 61.
3. wwrite=1, fs=4, 8 beats, src_ready low for 3 cycles mid-stream:
   - (kn,prm_a) sequence is (0,0..3) then (1,0..3).
   - Values hold while src_ready is low.
4. rst_n low during EXEC of pixel 2: all outputs 0 asynchronously. After release, a new s_init restarts at oy=ox=0 and ia=0.
5. s_init with run=0, and a second s_init while busy: both are ignored. Exactly one s_fin is produced per accepted s_init.
6. bwrite=1, 16 beats: kn counts 0..15 with prm_a=0 on every beat, then kn wraps to 0.
